main_mem_responder: RTL and testbench

Main-memory responder for the cache datapath: the far end of the cache controller's memory handshake (`rRead`/`rWrite` in, `memReady` out). It models a slow word-addressed backing store. On a block read it waits a fixed access latency, bursts one word per cycle into a block register, then pulses `memReady`; on a word write it stores the word after the same latency and pulses `memReady`.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/mem_array.sv | 26 ++
 rtl/main_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_main_mem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache datapath: responder FSM states,
// default word/block geometry, the address-check limit and block-base masking.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST,
        ST_WRITE,
        ST_DONE
    } mem_state_e;

    localparam int          ADDR_W_DEF = 10;
    localparam int          WORD_W_DEF = 32;
    localparam int          WORDS_DEF  = 4;
    localparam int unsigned MEM_LIMIT  = (2 ** ADDR_W_DEF) - 64;

    // Clears the in-block word offset; words must be a power of two.
    function automatic logic [31:0] blk_base(input logic [31:0] a, input int unsigned words);
        return a & ~(words - 32'd1);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port backing store: synchronous write, registered (1-cycle) read.
// Contents are deliberately not reset.
module mem_array #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/main_mem_responder.sv
// Slow main-memory model answering the cache's rRead/rWrite handshake with memReady.
// Define MEM_ADDR_CHECK_EN to add addrErr and suppress accesses at or above MEM_LIMIT.
module main_mem_responder
    import cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int WORD_W  = WORD_W_DEF,
    parameter int WORDS   = WORDS_DEF,
    parameter int LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rRead,
    input  logic                    rWrite,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [WORD_W-1:0]       wData,
    output logic [WORDS*WORD_W-1:0] blockOut,
    output logic                    memReady
`ifdef MEM_ADDR_CHECK_EN
    ,
    output logic                    addrErr
`endif
);

    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
`ifdef MEM_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    mem_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    drain_q, drain_d;
    logic                    op_rd_q, op_rd_d;
    logic                    err_q, err_d;
    logic                    rd_vld_q, rd_vld_d;
    logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
    logic [WORDS*WORD_W-1:0] block_q, block_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [WORD_W-1:0]       wdata_q, wdata_d;

    logic                    active_req;
    logic                    addr_over;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [WORD_W-1:0]       mem_rdata;

    assign active_req = op_rd_q ? rRead : rWrite;
    assign addr_over  = CHECK_EN && (32'(addr) >= MEM_LIMIT);

    mem_array #(
        .ADDR_W(ADDR_W),
        .WORD_W(WORD_W)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(wdata_q),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Any drop of the active request before completion abandons the transaction.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rRead || rWrite) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!active_req)      state_d = ST_IDLE;
                else if (cnt_q == '0) state_d = op_rd_q ? ST_BURST : ST_WRITE;
            end
            ST_BURST: begin
                if (!rRead)       state_d = ST_IDLE;
                else if (drain_q) state_d = ST_DONE;
            end
            ST_WRITE: begin
                state_d = rWrite ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        drain_d  = drain_q;
        op_rd_d  = op_rd_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        block_d  = block_q;
        rd_vld_d = (state_q == ST_BURST) && !drain_q;
        rd_idx_d = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (rRead || rWrite) begin
                    cnt_d   = CNT_W'(LATENCY - 1);
                    idx_d   = '0;
                    drain_d = 1'b0;
                    op_rd_d = rRead;
                    err_d   = addr_over;
                    addr_d  = rRead ? ADDR_W'(blk_base(32'(addr), WORDS)) : addr;
                    if (!rRead) wdata_d = wData;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            ST_BURST: begin
                // drain_q marks the extra cycle while the last word is still in flight.
                if (!drain_q) begin
                    if (idx_q == IDX_W'(WORDS - 1)) drain_d = 1'b1;
                    else                            idx_d   = idx_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (rd_vld_q) begin
            block_d[rd_idx_q*WORD_W +: WORD_W] = err_q ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            drain_q  <= 1'b0;
            op_rd_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
            block_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            drain_q  <= drain_d;
            op_rd_q  <= op_rd_d;
            err_q    <= err_d;
            rd_vld_q <= rd_vld_d;
            rd_idx_q <= rd_idx_d;
            block_q  <= block_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    always_comb begin
        memReady = (state_q == ST_DONE);
        mem_we   = (state_q == ST_WRITE) && rWrite && !err_q;
        mem_addr = addr_q | ADDR_W'(idx_q);
    end

    assign blockOut = block_q;
`ifdef MEM_ADDR_CHECK_EN
    assign addrErr = (state_q == ST_DONE) && err_q;
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed and randomized bench for main_mem_responder against an associative-array memory model.
// Builds with or without MEM_ADDR_CHECK_EN.
module tb_main_mem_responder;
    import cache_pkg::*;

    localparam int ADDR_W   = 10;
    localparam int WORD_W   = 32;
    localparam int WORDS    = 4;
    localparam int LATENCY  = 4;
    localparam int RD_EDGES = LATENCY + WORDS + 1;
    localparam int WR_EDGES = LATENCY + 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    rRead = 1'b0;
    logic                    rWrite = 1'b0;
    logic [ADDR_W-1:0]       addr = '0;
    logic [WORD_W-1:0]       wData = '0;
    logic [WORDS*WORD_W-1:0] blockOut;
    logic                    memReady;
`ifdef MEM_ADDR_CHECK_EN
    logic                    addr_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [WORD_W-1:0]       model [int];
    int                      written_q [$];
    logic [WORDS*WORD_W-1:0] last_block;

    main_mem_responder #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W),
        .WORDS  (WORDS),
        .LATENCY(LATENCY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rRead   (rRead),
        .rWrite  (rWrite),
        .addr    (addr),
        .wData   (wData),
        .blockOut(blockOut),
        .memReady(memReady)
`ifdef MEM_ADDR_CHECK_EN
        ,
        .addrErr (addr_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Holds the request until memReady, returns edges counted after the accepting edge.
    task automatic do_req(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [WORD_W-1:0] d, output int n);
        @(negedge clk);
        rRead = rd; rWrite = wr; addr = a; wData = d;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!memReady && n < 40);
`ifdef MEM_ADDR_CHECK_EN
        check("addr_err_with_ready", addr_err, 128'(32'(a) >= MEM_LIMIT));
`endif
        rRead = 1'b0; rWrite = 1'b0;
        @(posedge clk); #1;
        check("ready_pulse_width", memReady, 0);
`ifdef MEM_ADDR_CHECK_EN
        check("addr_err_pulse_width", addr_err, 0);
`endif
    endtask

    task automatic check_block(input string tag, input logic [ADDR_W-1:0] a);
        int base;
        base = int'(a) & ~(WORDS - 1);
        for (int w = 0; w < WORDS; w++) begin
            if (model.exists(base + w))
                check(tag, 128'(blockOut[w*WORD_W +: WORD_W]), 128'(model[base + w]));
        end
    endtask

    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        int n;
        do_req(1'b0, 1'b1, a, d, n);
        check("write_latency", n, WR_EDGES);
        check("write_holds_block", blockOut, last_block);
        if (!model.exists(int'(a))) written_q.push_back(int'(a));
        model[int'(a)] = d;
    endtask

    task automatic model_read(input logic [ADDR_W-1:0] a);
        int n;
        do_req(1'b1, 1'b0, a, '0, n);
        check("read_latency", n, RD_EDGES);
        check_block("read_word", a);
        last_block = blockOut;
    endtask

    initial begin
        int n;
        logic seen;
        logic [WORDS*WORD_W-1:0] exp_blk;

        #2;
        check("reset_ready", memReady, 0);
        check("reset_block", blockOut, 0);
`ifdef MEM_ADDR_CHECK_EN
        check("reset_addr_err", addr_err, 0);
`endif
        last_block = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Preload 0x40..0x43 and fetch via an unaligned address inside the block.
        for (int i = 0; i < WORDS; i++)
            model_write(ADDR_W'(32'h40 + i), 32'hA0 + i);
        model_read(10'h042);
        exp_blk = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        check("preload_block", blockOut, exp_blk);

        model_write(10'h010, 32'hDEADBEEF);
        model_read(10'h010);
        check("write_then_read", blockOut[WORD_W-1:0], 32'hDEADBEEF);

        // Simultaneous read and write: read must win and the write must not land.
        do_req(1'b1, 1'b1, 10'h041, 32'h12345678, n);
        check("both_latency", n, RD_EDGES);
        check("both_block", blockOut, exp_blk);
        model_read(10'h041);
        check("both_no_write", blockOut[WORD_W +: WORD_W], 32'hA1);

        // Abort during the burst.
        @(negedge clk);
        rRead = 1'b1; addr = 10'h010;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1 rRead = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (memReady) seen = 1'b1;
        end
        check("abort_no_ready", seen, 0);
        model_read(10'h040);

        // Asynchronous reset while waiting.
        @(negedge clk);
        rRead = 1'b1; addr = 10'h010;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_ready", memReady, 0);
        check("rst_mid_block", blockOut, 0);
        rRead = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_block = '0;
        model_read(10'h043);
        model_read(10'h010);

        // Randomized traffic below the check limit.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0)
                model_write(ADDR_W'($urandom_range(0, 959)), $urandom);
            else
                model_read(ADDR_W'(written_q[$urandom_range(0, written_q.size() - 1)]));
        end

`ifdef MEM_ADDR_CHECK_EN
        do_req(1'b1, 1'b0, ADDR_W'(MEM_LIMIT), '0, n);
        check("limit_read_latency", n, RD_EDGES);
        check("limit_read_zero", blockOut, 0);
        do_req(1'b0, 1'b1, ADDR_W'(MEM_LIMIT + 5), 32'h55AA55AA, n);
        check("limit_write_latency", n, WR_EDGES);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
